uart_rx_fifo: RTL

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 133 +++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// ------------
// Receive-side buffer that sits behind a UART receiver. Each completed frame
// arrives as a one-cycle rx_valid strobe. Frames that have a stop-bit error are
// counted and discarded. Good bytes are queued into a show-ahead FIFO for the
// consumer. A good byte that arrives while the FIFO is full, with no pop in the
// same cycle, is dropped and sets the sticky overflow flag.
//
// Ports
//   clk            in   single clock, rising edge
//   rst            in   asynchronous, active-high reset
//   rx_data        in   DATA_W  received byte, meaningful only with rx_valid
//   rx_valid       in   1       one-cycle strobe per completed frame
//   rx_frame_err   in   1       qualifies rx_valid: stop bit was sampled low
//   rd_en          in   1       consumer pop request
//   rd_data        out  DATA_W  head entry (show-ahead), don't-care while empty
//   empty          out  1       no entries stored
//   full           out  1       DEPTH entries stored
//   count          out  AW+1    number of stored entries
//   overflow       out  1       sticky: a good byte was dropped because full
//   frame_err_cnt  out  8       saturating count of rejected frames
//   clr_err        in   1       one-cycle clear of overflow and frame_err_cnt
//
// Handshake: the producer side has no back-pressure. A strobe is either stored,
// counted as a framing error, or dropped as an overflow in the cycle where it
// is presented. The consumer side is show-ahead. rd_data is valid whenever
// empty=0. A pop takes effect on the edge where rd_en=1 and empty=0. rd_en
// while empty is ignored.

module uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              rx_frame_err,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [AW:0]       count,
  output logic              overflow,
  output logic [7:0]        frame_err_cnt,
  input  logic              clr_err
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       cnt;

  logic good_frame;
  logic bad_frame;
  logic pop;
  logic push;
  logic drop;

  // Flags come straight from the registered count. No rx_* input reaches
  // them, or rd_data, combinationally.
  assign empty = (cnt == '0);
  assign full  = (cnt == DEPTH_CNT);
  assign count = cnt;

  assign good_frame = rx_valid && !rx_frame_err;
  assign bad_frame  = rx_valid &&  rx_frame_err;
  assign pop        = rd_en && !empty;
  // When the FIFO is full, a pop in the same cycle frees the slot the new
  // byte needs, so the write is still accepted.
  assign push       = good_frame && (!full || pop);
  assign drop       = good_frame && full && !pop;

  assign rd_data = mem[rd_ptr];

  // Storage is intentionally not reset. Its contents are unreachable while
  // the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  // Pointers wrap naturally because they are exactly AW bits wide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        cnt <= cnt + 1'b1;
      end else if (pop && !push) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Error bookkeeping. When an error event coincides with clr_err, the new
  // event wins: the flag or counter restarts at 1 rather than 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow      <= 1'b0;
      frame_err_cnt <= '0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end

      if (bad_frame) begin
        if (clr_err) begin
          frame_err_cnt <= 8'd1;
        end else if (frame_err_cnt != 8'hFF) begin
          frame_err_cnt <= frame_err_cnt + 8'd1;
        end
      end else if (clr_err) begin
        frame_err_cnt <= '0;
      end
    end
  end

endmodule
